// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_ctrl
// Brief   : MEM-stage load/store initiator for a word-wide data RAM. It handles
//           byte-lane extraction, and it performs byte stores as read-modify-write.
// Revision: 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int IDX_W     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_en,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    DONE    = 3'd4,
    ERR     = 3'd5
  } state_t;

  localparam logic [29:0] c_DEPTH = 30'(MEM_DEPTH);

  state_t      state_q, state_d;
  logic        wr_q, wr_d;
  logic        byte_q, byte_d;
  logic        sgn_q, sgn_d;
  logic [1:0]  lane_q, lane_d;
  logic [7:0]  wbyte_q, wbyte_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_rw_q, mem_rw_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        accept;
  logic        addr_bad;
  logic [31:0] req_idx;
  logic [7:0]  lane_byte;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign accept   = req_valid & req_ready_q;
  // Upper address bits must be clear; the index never wraps into low words.
  assign addr_bad = (!req_byte && (req_addr[1:0] != 2'b00))
                  || (req_addr[31:IDX_W+2] != '0)
                  || (req_addr[31:2] >= c_DEPTH);
  assign req_idx  = {{(32-IDX_W){1'b0}}, req_addr[IDX_W+1:2]};

  always_comb begin
    lane_byte = mem_rdata[{lane_q, 3'b000} +: 8];
    load_data = byte_q ? {{24{sgn_q & lane_byte[7]}}, lane_byte} : mem_rdata;
    merged    = mem_rdata;
    merged[{lane_q, 3'b000} +: 8] = wbyte_q;
  end

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    byte_d      = byte_q;
    sgn_d       = sgn_q;
    lane_d      = lane_q;
    wbyte_d     = wbyte_q;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = 1'b0;
    mem_en_d    = 1'b0;
    mem_rw_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (accept) begin
          wr_d        = req_write;
          byte_d      = req_byte;
          sgn_d       = req_signed;
          lane_d      = req_addr[1:0];
          wbyte_d     = req_wdata[7:0];
          req_ready_d = 1'b0;
          if (addr_bad) begin
            state_d     = ERR;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (req_write && !req_byte) begin
            state_d     = WR;
            mem_en_d    = 1'b1;
            mem_rw_d    = 1'b1;
            mem_addr_d  = req_idx;
            mem_wdata_d = req_wdata;
          end else begin
            state_d    = RD;
            mem_en_d   = 1'b1;
            mem_addr_d = req_idx;
          end
        end
      end
      RD: state_d = RD_WAIT;
      RD_WAIT: begin
        // RAM data is valid here, one cycle after the read Enable.
        if (wr_q) begin
          state_d     = WR;
          mem_en_d    = 1'b1;
          mem_rw_d    = 1'b1;
          mem_wdata_d = merged;
        end else begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_data;
        end
      end
      WR: begin
        state_d     = DONE;
        rsp_valid_d = 1'b1;
      end
      DONE, ERR: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      byte_q      <= 1'b0;
      sgn_q       <= 1'b0;
      lane_q      <= 2'b00;
      wbyte_q     <= 8'h00;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      byte_q      <= byte_d;
      sgn_q       <= sgn_d;
      lane_q      <= lane_d;
      wbyte_q     <= wbyte_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_en_q    <= mem_en_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_en    = mem_en_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_access_ctrl
// Brief   : Directed bench for mem_access_ctrl, driving it against a behavioural
//           256x32 RAM that returns read data one cycle after Enable.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_byte;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_en;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram [256];
  int          cyc = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          viol = 0;
  logic        prev_en = 1'b0;
  logic [31:0] last_addr = 32'h0;

  mem_access_ctrl #(.MEM_DEPTH(256), .IDX_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_byte(req_byte), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM plus port-rule monitor.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    prev_en <= mem_en;
    if (mem_en && prev_en) viol <= viol + 1;
    if (mem_rw && !mem_en) viol <= viol + 1;
    if (mem_en) begin
      last_addr <= mem_addr;
      if (mem_rw) begin
        ram[mem_addr[7:0]] <= mem_wdata;
        wr_cnt <= wr_cnt + 1;
      end else begin
        mem_rdata <= ram[mem_addr[7:0]];
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input string tag, input logic w, input logic b, input logic s,
                        input logic [31:0] a, input logic [31:0] d, input int exp_lat,
                        input logic exp_err, input logic chk_rd, input logic [31:0] exp_rd,
                        input int exp_nrd, input int exp_nwr);
    int n;
    int rd0;
    int wr0;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    req_write = w; req_byte = b; req_signed = s; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin step(); n++; end
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    check({tag, "_lat"}, 32'(n + 1), 32'(exp_lat));
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    if (chk_rd) check({tag, "_rdata"}, rsp_rdata, exp_rd);
    check({tag, "_nrd"}, 32'(rd_cnt - rd0), 32'(exp_nrd));
    check({tag, "_nwr"}, 32'(wr_cnt - wr0), 32'(exp_nwr));
    step();
    check({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
    check({tag, "_idle"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] addrs [3];
    logic [31:0] datas [3];
    int          acc [3];
    int          n;
    int          wr0;

    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    rst_n = 1'b1;
    step();

    // Word store then word load at 0x010 (index 4).
    do_req("wst", 1, 0, 0, 32'h010, 32'hDEADBEEF, 2, 0, 0, 32'h0, 0, 1);
    check("wst_idx", last_addr, 32'd4);
    check("wst_ram", ram[4], 32'hDEADBEEF);
    do_req("wld", 0, 0, 0, 32'h010, 32'h0, 3, 0, 1, 32'hDEADBEEF, 1, 0);

    // Byte store read-modify-write; upper wdata bits must be ignored.
    do_req("pre1", 1, 0, 0, 32'h010, 32'h11223344, 2, 0, 0, 32'h0, 0, 1);
    do_req("bst", 1, 1, 0, 32'h012, 32'hFFFFFFAB, 4, 0, 0, 32'h0, 1, 1);
    check("bst_ram", ram[4], 32'h11AB3344);
    do_req("bst_ld", 0, 0, 0, 32'h010, 32'h0, 3, 0, 1, 32'h11AB3344, 1, 0);

    // Byte loads with sign and zero extension.
    do_req("pre2", 1, 0, 0, 32'h010, 32'h80FF7F01, 2, 0, 0, 32'h0, 0, 1);
    do_req("bl0u", 0, 1, 0, 32'h010, 32'h0, 3, 0, 1, 32'h00000001, 1, 0);
    do_req("bl1s", 0, 1, 1, 32'h011, 32'h0, 3, 0, 1, 32'h0000007F, 1, 0);
    do_req("bl3s", 0, 1, 1, 32'h013, 32'h0, 3, 0, 1, 32'hFFFFFF80, 1, 0);
    do_req("bl2s", 0, 1, 1, 32'h012, 32'h0, 3, 0, 1, 32'hFFFFFFFF, 1, 0);
    do_req("bl3u", 0, 1, 0, 32'h013, 32'h0, 3, 0, 1, 32'h00000080, 1, 0);

    // Errors: misaligned word, just past the top word, out-of-range byte store.
    do_req("e_mis", 0, 0, 0, 32'h006, 32'h0, 1, 1, 1, 32'h00000080, 0, 0);
    do_req("e_oor", 0, 0, 0, 32'h400, 32'h0, 1, 1, 1, 32'h00000080, 0, 0);
    do_req("e_bst", 1, 1, 0, 32'h401, 32'h5A, 1, 1, 1, 32'h00000080, 0, 0);
    check("e_ram", ram[4], 32'h80FF7F01);

    // Held req_valid: three word loads including the top word.
    addrs[0] = 32'h000; addrs[1] = 32'h004; addrs[2] = 32'h3FC;
    datas[0] = 32'h01234567; datas[1] = 32'h89ABCDEF; datas[2] = 32'hCAFEF00D;
    do_req("p0", 1, 0, 0, addrs[0], datas[0], 2, 0, 0, 32'h0, 0, 1);
    do_req("p1", 1, 0, 0, addrs[1], datas[1], 2, 0, 0, 32'h0, 0, 1);
    do_req("p2", 1, 0, 0, addrs[2], datas[2], 2, 0, 0, 32'h0, 0, 1);
    check("top_idx", last_addr, 32'd255);
    req_write = 1'b0; req_byte = 1'b0; req_signed = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr = addrs[i];
      n = 0;
      while (!req_ready && n < 50) begin step(); n++; end
      acc[i] = cyc + 1;
      step();
      n = 0;
      while (!rsp_valid && n < 20) begin step(); n++; end
      check("held_lat", 32'(n + 1), 32'd3);
      check("held_rdata", rsp_rdata, datas[i]);
      check("held_err", 32'(rsp_err), 32'd0);
    end
    req_valid = 1'b0;
    check("held_gap01", 32'(acc[1] - acc[0]), 32'd4);
    check("held_gap12", 32'(acc[2] - acc[1]), 32'd4);
    step();

    // Reset during the write phase of a byte store.
    wr0 = wr_cnt;
    req_write = 1'b1; req_byte = 1'b1; req_signed = 1'b0;
    req_addr = 32'h011; req_wdata = 32'h55;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin step(); n++; end
    step();
    req_valid = 1'b0;
    n = 0;
    while (!(mem_en && mem_rw) && n < 20) begin step(); n++; end
    check("rmw_in_wr", 32'({mem_en, mem_rw}), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_mem_en", 32'(mem_en), 32'd0);
    check("ar_mem_rw", 32'(mem_rw), 32'd0);
    check("ar_mem_addr", mem_addr, 32'h0);
    check("ar_mem_wdata", mem_wdata, 32'h0);
    check("ar_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
    check("ar_rdata", rsp_rdata, 32'h0);
    check("ar_ready", 32'(req_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    check("ar_ram", ram[4], 32'h80FF7F01);
    check("ar_nwr", 32'(wr_cnt - wr0), 32'd0);
    do_req("ar_ld", 0, 0, 0, 32'h010, 32'h0, 3, 0, 1, 32'h80FF7F01, 1, 0);

    check("port_rules", 32'(viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage initiator for the 256x32 data RAM.
- Accepts one load or store request at a time from the pipeline MEM stage.
- Converts the byte address to a RAM word index and drives the RAM Enable/ReadWrite/Address/DataIn port.
- Captures DataOut, performs byte-lane extraction with sign/zero extension, and implements byte stores as read-modify-write on the word-wide RAM.

Parameters:
- MEM_DEPTH, 256, number of 32-bit RAM words; legal word index range is 0..MEM_DEPTH-1.
- IDX_W, 8, width of the word index (log2 MEM_DEPTH); RAM address = {24'b0, addr[IDX_W+1:2]}.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle, request accepted on clk edge when req_valid & req_ready.
- req_write  in  1  0 load, 1 store.
- req_byte  in  1  0 word access, 1 byte access.
- req_signed  in  1  byte loads only: 1 sign-extend, 0 zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data (byte store uses bits [7:0]).
- rsp_valid  out  1  one-cycle pulse, request completed.
- rsp_rdata  out  32  load result, valid with rsp_valid; holds until next rsp_valid.
- rsp_err  out  1  valid with rsp_valid: misaligned word or out-of-range address, no RAM access made.
- mem_en  out  1  RAM Enable.
- mem_rw  out  1  RAM ReadWrite (0 read, 1 write).
- mem_addr  out  32  RAM word index.
- mem_wdata  out  32  RAM DataIn.
- mem_rdata  in  32  RAM DataOut.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, req_ready=1.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - mem_en=0, mem_rw=0, mem_addr=0, mem_wdata=0.
  - All latched request fields cleared.
  - Reset mid-operation abandons the access. A partially completed RMW never writes.
- All outputs are registered.
- States: IDLE, RD, RD_WAIT, WR, DONE, ERR.
- IDLE:
  - req_ready=1.
  - On accept: latch write/byte/signed/addr/wdata; req_ready=0 next cycle.
  - Error check on accept: if (!req_byte & addr[1:0]!=0) or addr[31:IDX_W+2]!=0, go to ERR.
  - Otherwise: store word -> WR; any load or byte store -> RD.
- RD: mem_en=1, mem_rw=0, mem_addr=word index. Next state RD_WAIT.
- RD_WAIT:
  - mem_en=0. Capture mem_rdata (RAM data is valid the cycle after Enable rises).
  - Load: extract result into rsp_rdata, then DONE.
  - Byte store: merged word = captured word with lane addr[1:0] replaced by wdata[7:0], then WR.
- WR:
  - mem_en=1, mem_rw=1, mem_addr=word index.
  - mem_wdata = wdata (word store) or merged word (byte store).
  - Next state DONE.
- DONE:
  - mem_en=0, mem_rw=0.
  - rsp_valid=1, rsp_err=0 for exactly one cycle.
  - Next state IDLE. req_ready returns to 1 in the same cycle.
- ERR: rsp_valid=1, rsp_err=1 for one cycle; no mem_en pulse; rsp_rdata unchanged. Next state IDLE.
- Byte lanes are little-endian: lane n = bits [8n+7:8n].
- Byte load result: lane value in [7:0]; [31:8] = req_signed ? {24{bit7}} : 0.
- RAM port rules:
  - mem_rw=1 only while mem_en=1; both deassert on the same edge.
  - mem_addr and mem_wdata are stable for the whole cycle mem_en=1.
  - mem_en is never high two consecutive cycles, so every access is a fresh Enable edge.
- Latency, accept edge = T:
  - word load: rsp_valid at T+3.
  - word store: rsp_valid at T+2.
  - byte load: rsp_valid at T+3.
  - byte store: rsp_valid at T+4.
  - error: rsp_valid at T+1.
- req_valid while busy: ignored (req_ready=0). The requester must hold it.
- Back-to-back requests: a new accept is possible on the edge after DONE/ERR.
- Top valid address is 0x3FC (index 255). 0x400 is out of range and reports an error; the index never wraps.

Test Plan:
- Word store 0xDEADBEEF to 0x010, then word load 0x010 -> one mem_en write at index 4; load rsp_rdata=0xDEADBEEF; rsp_err=0; rsp_valid at T+2 and T+3 respectively.
- Preload index 4 = 0x11223344; byte store 0xAB to 0x012 -> RAM index 4 = 0x11AB3344; exactly one read then one write Enable pulse.
- Index 4 = 0x80FF7F01; byte loads 0x010/0x011/0x013, signed and unsigned -> 0x00000001, 0x0000007F, signed 0xFFFFFF80 / unsigned 0x00000080.
- Word load 0x006 and word load 0x400 -> rsp_valid with rsp_err=1 at T+1; mem_en stays 0; rsp_rdata unchanged.
- req_valid held high continuously for 3 word loads at 0x000/0x004/0x3FC -> accepts spaced 4 cycles apart; mem_en never high two consecutive cycles; correct data each.
- Assert rst_n=0 during WR of a byte store -> all outputs 0, req_ready=1 immediately; RAM word unmodified; the next request completes normally.
